// File: rtl/imem_pkg.sv
// Shared types and constants for the writable instruction memory and its loader.
package imem_pkg;

  // Loader progress: the image is streamed in, the final partial word is padded, then fetches are served.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PAD,
    DONE,
    ERROR
  } loader_state_t;

  localparam logic [31:0] NOP_INSTR      = 32'h00000013;
  localparam int          BYTES_PER_WORD = 4;
  localparam int          BYTE_WIDTH     = 8;

  // True when a byte address is the last byte of its 32-bit word.
  function automatic logic is_word_end(input logic [1:0] addr_lo);
    return addr_lo == 2'(BYTES_PER_WORD - 1);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Handshaked byte stream that carries the program image into the loader.
interface imem_loader_if;
  import imem_pkg::*;

  logic [BYTE_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;

  // Image source drives bytes; the loader answers with ready.
  modport master (output in_data, output in_valid, output in_last, input in_ready);
  modport slave  (input in_data, input in_valid, input in_last, output in_ready);

endinterface

// File: rtl/imem_bytes.sv
// Byte-addressed storage: one synchronous byte write port and an asynchronous
// little-endian 32-bit read port whose address wraps around the array.
module imem_bytes
  import imem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [ADDRESS_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [ADDRESS_WIDTH-1:0]  raddr,
  output logic [4*DATA_WIDTH-1:0]   rdata
);

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE   = 1;
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_TWO   = 2;
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_THREE = 3;

  logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];

  logic [ADDRESS_WIDTH-1:0] raddr_1;
  logic [ADDRESS_WIDTH-1:0] raddr_2;
  logic [ADDRESS_WIDTH-1:0] raddr_3;

  // Byte write port.
  // NOTE: the array has no reset; clearing thousands of flops buys nothing since every
  // fetched word of a correct program is written before the CPU leaves reset.
  // NOTE: sequential logic uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Fetch addresses wrap naturally in ADDRESS_WIDTH-bit arithmetic.
  assign raddr_1 = raddr + ADDR_ONE;
  assign raddr_2 = raddr + ADDR_TWO;
  assign raddr_3 = raddr + ADDR_THREE;

  // Little-endian word assembly: lowest address in the least significant byte.
  assign rdata = {mem[raddr_3], mem[raddr_2], mem[raddr_1], mem[raddr]};

endmodule

// File: rtl/imem_loader.sv
// Instruction memory with a byte-stream program loader. Holds the CPU in reset
// until the whole image (zero-padded to a word boundary) is in memory.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  imem_loader_if.slave             in_if,
  input  logic [ADDRESS_WIDTH-1:0] PC,
  output logic [31:0]              instr,
  output logic                     cpu_rst_n,
  output logic                     load_err,
  output logic [ADDRESS_WIDTH:0]   byte_count
);

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDRESS_WIDTH:0]   CNT_ONE  = 1;

  loader_state_t            state;
  loader_state_t            state_nxt;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [ADDRESS_WIDTH-1:0] wr_addr_nxt;
  logic [ADDRESS_WIDTH:0]   byte_count_nxt;
  logic                     accept;
  logic                     mem_we;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [4*DATA_WIDTH-1:0]  fetch_word;

  // Ready is a decode of the registered state; a byte held during reset is never taken.
  assign in_if.in_ready = (state == IDLE) || (state == LOAD);
  assign accept         = in_if.in_valid && in_if.in_ready && rst_n;

  // Loader state, write pointer and accepted-byte counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_addr    <= '0;
      byte_count <= '0;
    end else begin
      state      <= state_nxt;
      wr_addr    <= wr_addr_nxt;
      byte_count <= byte_count_nxt;
    end
  end

  // Next-state, write-port and pad-mux decode.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the case leaves a latch.
    state_nxt      = state;
    wr_addr_nxt    = wr_addr;
    byte_count_nxt = byte_count;
    mem_we         = 1'b0;
    mem_wdata      = DATA_WIDTH'(in_if.in_data);

    unique case (state)
      IDLE, LOAD: begin
        if (accept) begin
          mem_we         = 1'b1;
          wr_addr_nxt    = wr_addr + ADDR_ONE;
          byte_count_nxt = byte_count + CNT_ONE;
          if (in_if.in_last) begin
            state_nxt = is_word_end(wr_addr[1:0]) ? DONE : PAD;
          end else if (&wr_addr) begin
            // The byte in the top location is kept, but the image did not fit.
            state_nxt = ERROR;
          end else begin
            state_nxt = LOAD;
          end
        end
      end
      PAD: begin
        // Zero-fill the rest of the final word; the stream count is untouched.
        mem_we      = 1'b1;
        mem_wdata   = '0;
        wr_addr_nxt = wr_addr + ADDR_ONE;
        if (is_word_end(wr_addr[1:0])) begin
          state_nxt = DONE;
        end
      end
      default: begin
        // DONE and ERROR hold until reset.
      end
    endcase
  end

  imem_bytes #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_bytes (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_addr),
    .wdata (mem_wdata),
    .raddr (PC),
    .rdata (fetch_word)
  );

  // Outputs decode the registered state, so cpu_rst_n cannot glitch.
  assign cpu_rst_n = (state == DONE);
  assign load_err  = (state == ERROR);
  assign instr     = (state == DONE) ? 32'(fetch_word) : NOP_INSTR;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a 12-bit and a 4-bit instance share clock and reset.
// Stimulus pushes expected values onto a scoreboard queue; a monitor pops and
// compares on the falling edge whenever a sample is requested.
module tb_imem_loader;
  import imem_pkg::*;

  typedef enum int {F_INSTR, F_CPU_RST, F_ERR, F_COUNT, F_READY} field_e;

  typedef struct {
    string       name;
    int          sel;
    field_e      fld;
    logic [31:0] expv;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [11:0] pc_a;
  logic [3:0]  pc_b;
  logic [31:0] instr_a;
  logic [31:0] instr_b;
  logic        cpu_a;
  logic        cpu_b;
  logic        err_a;
  logic        err_b;
  logic [12:0] bc_a;
  logic [4:0]  bc_b;
  logic        chk_strobe;

  exp_t        sb[$];
  exp_t        cur;
  logic [31:0] act;
  int          n_checks  = 0;
  int          n_pass    = 0;
  int          n_timeout = 0;

  imem_loader_if ifa ();
  imem_loader_if ifb ();

  imem_loader #(.ADDRESS_WIDTH(12), .DATA_WIDTH(8)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (ifa),
    .PC         (pc_a),
    .instr      (instr_a),
    .cpu_rst_n  (cpu_a),
    .load_err   (err_a),
    .byte_count (bc_a)
  );

  imem_loader #(.ADDRESS_WIDTH(4), .DATA_WIDTH(8)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (ifb),
    .PC         (pc_b),
    .instr      (instr_b),
    .cpu_rst_n  (cpu_b),
    .load_err   (err_b),
    .byte_count (bc_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] actual(input int sel, input field_e fld);
    logic [31:0] v;
    v = '0;
    case (fld)
      F_INSTR:   v = (sel == 0) ? instr_a : instr_b;
      F_CPU_RST: v = {31'b0, (sel == 0) ? cpu_a : cpu_b};
      F_ERR:     v = {31'b0, (sel == 0) ? err_a : err_b};
      F_COUNT:   v = (sel == 0) ? 32'(bc_a) : 32'(bc_b);
      F_READY:   v = {31'b0, (sel == 0) ? ifa.in_ready : ifb.in_ready};
      default:   v = 'x;
    endcase
    return v;
  endfunction

  // Monitor: pop one expectation per requested sample and compare.
  always @(negedge clk) begin
    if (chk_strobe) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL scoreboard_empty: sample requested with no expectation queued");
      end else begin
        cur = sb.pop_front();
        act = actual(cur.sel, cur.fld);
        if (act === cur.expv) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got %h, expected %h", cur.name, act, cur.expv);
        end
      end
    end
  end

  // Queue an expectation, point the fetch port, and request one sample.
  task automatic check(input string name, input int sel, input field_e fld,
                       input logic [31:0] pc, input logic [31:0] expv);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.fld  = fld;
    e.expv = expv;
    sb.push_back(e);
    if (sel == 0) pc_a = pc[11:0];
    else          pc_b = pc[3:0];
    chk_strobe = 1'b1;
    @(posedge clk);
    #1;
    chk_strobe = 1'b0;
  endtask

  task automatic drive(input int sel, input logic v, input logic [7:0] d, input logic l);
    if (sel == 0) begin
      ifa.in_valid = v;
      ifa.in_data  = d;
      ifa.in_last  = l;
    end else begin
      ifb.in_valid = v;
      ifb.in_data  = d;
      ifb.in_last  = l;
    end
  endtask

  function automatic logic ready_of(input int sel);
    return (sel == 0) ? ifa.in_ready : ifb.in_ready;
  endfunction

  // Offer one byte and wait (bounded) for it to be taken. Valid stays high
  // afterwards so consecutive calls stream back-to-back, except after last.
  task automatic send(input int sel, input logic [7:0] d, input logic l);
    int n;
    n = 0;
    drive(sel, 1'b1, d, l);
    @(negedge clk);
    while (!ready_of(sel) && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      n_timeout++;
      $display("FAIL send_timeout: dut %0d never ready for byte %h", sel, d);
    end
    @(posedge clk);
    #1;
    if (l) drive(sel, 1'b0, 8'h00, 1'b0);
  endtask

  // Drop valid and idle for n cycles.
  task automatic gap(input int sel, input int n);
    drive(sel, 1'b0, 8'h00, 1'b0);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [7:0] t1 [8]  = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
  logic [7:0] t2 [6]  = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};

  initial begin
    rst_n      = 1'b0;
    chk_strobe = 1'b0;
    pc_a       = '0;
    pc_b       = '0;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Reset values; ready is already high while reset is held.
    check("rst_ready", 0, F_READY, 0, 1);
    rst_n = 1'b1;
    check("rst_cpu", 0, F_CPU_RST, 0, 0);
    check("rst_err", 0, F_ERR, 0, 0);
    check("rst_count", 0, F_COUNT, 0, 0);
    check("rst_nop_pc0", 0, F_INSTR, 32'h000, NOP_INSTR);
    check("rst_nop_pc7fc", 0, F_INSTR, 32'h7FC, NOP_INSTR);

    // Full-word image, with a pause after the first word.
    for (int i = 0; i < 4; i++) send(0, t1[i], 1'b0);
    gap(0, 0);
    check("t1_pre_nop", 0, F_INSTR, 0, NOP_INSTR);
    check("t1_pre_cpu", 0, F_CPU_RST, 0, 0);
    for (int i = 4; i < 8; i++) send(0, t1[i], i == 7);
    check("t1_pc0", 0, F_INSTR, 0, 32'h00000513);
    check("t1_pc4", 0, F_INSTR, 4, 32'h00100593);
    check("t1_cpu", 0, F_CPU_RST, 0, 1);
    check("t1_count", 0, F_COUNT, 0, 8);
    check("t1_ready", 0, F_READY, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 8'hFF, 1'b1);
      @(posedge clk);
      #1;
      gap(0, 1);
    end
    check("t1_post_count", 0, F_COUNT, 0, 8);
    check("t1_post_pc0", 0, F_INSTR, 0, 32'h00000513);
    check("t1_post_pc4", 0, F_INSTR, 4, 32'h00100593);

    // Partial final word: two pad cycles, stale bytes at 6..7 must become zero.
    do_reset();
    for (int i = 0; i < 6; i++) send(0, t2[i], i == 5);
    check("t2_pad1_ready", 0, F_READY, 0, 0);
    check("t2_pad2_cpu", 0, F_CPU_RST, 0, 0);
    check("t2_done_cpu", 0, F_CPU_RST, 0, 1);
    check("t2_pc4", 0, F_INSTR, 4, 32'h00002211);
    check("t2_pc0", 0, F_INSTR, 0, 32'hDDCCBBAA);
    check("t2_count", 0, F_COUNT, 0, 6);

    // Gaps: a 3-cycle hold after byte 4, then valid toggling every cycle.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      send(0, 8'(i + 1), i == 11);
      if (i == 3) gap(0, 3);
      else if (i >= 4 && i < 11) gap(0, 1);
    end
    check("t3_pc0", 0, F_INSTR, 0, 32'h04030201);
    check("t3_pc4", 0, F_INSTR, 4, 32'h08070605);
    check("t3_pc8", 0, F_INSTR, 8, 32'h0C0B0A09);
    check("t3_count", 0, F_COUNT, 0, 12);

    // Reset part-way through a load, then a short image.
    do_reset();
    for (int i = 0; i < 5; i++) send(0, 8'(8'h50 + i), 1'b0);
    gap(0, 0);
    check("t4_mid_count", 0, F_COUNT, 0, 5);
    do_reset();
    check("t4_rst_count", 0, F_COUNT, 0, 0);
    for (int i = 0; i < 4; i++) send(0, 8'(i + 1), i == 3);
    check("t4_count", 0, F_COUNT, 0, 4);
    check("t4_pc0", 0, F_INSTR, 0, 32'h04030201);
    check("t4_err", 0, F_ERR, 0, 0);
    check("t4_cpu", 0, F_CPU_RST, 0, 1);

    // Single-byte image: three pad bytes overwrite the previous 02 03 04.
    do_reset();
    send(0, 8'h7F, 1'b1);
    check("t5_pad_ready", 0, F_READY, 0, 0);
    gap(0, 3);
    check("t5_pc0", 0, F_INSTR, 0, 32'h0000007F);
    check("t5_count", 0, F_COUNT, 0, 1);
    check("t5_cpu", 0, F_CPU_RST, 0, 1);

    // 16-byte array overflow: no last on the top byte.
    do_reset();
    for (int i = 0; i < 15; i++) send(1, 8'(i * 8'h11), 1'b0);
    gap(1, 0);
    check("t6_pre_err", 1, F_ERR, 0, 0);
    send(1, 8'hFF, 1'b0);
    gap(1, 0);
    check("t6_err", 1, F_ERR, 0, 1);
    check("t6_ready", 1, F_READY, 0, 0);
    check("t6_cpu", 1, F_CPU_RST, 0, 0);
    check("t6_nop", 1, F_INSTR, 0, NOP_INSTR);
    check("t6_count", 1, F_COUNT, 0, 16);

    // Exactly-full image with last on the top byte, plus wrapping fetch.
    do_reset();
    check("t7_rst_err", 1, F_ERR, 0, 0);
    for (int i = 0; i < 16; i++) send(1, 8'(8'hA0 + i), i == 15);
    check("t7_cpu", 1, F_CPU_RST, 0, 1);
    check("t7_err", 1, F_ERR, 0, 0);
    check("t7_count", 1, F_COUNT, 0, 16);
    check("t7_pc0", 1, F_INSTR, 0, 32'hA3A2A1A0);
    check("t7_pc12", 1, F_INSTR, 12, 32'hAFAEADAC);
    check("t7_pc14_wrap", 1, F_INSTR, 14, 32'hA1A0AFAE);

    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      n_timeout++;
      $display("FAIL scoreboard_leftover: %0d expectations never sampled", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks + n_timeout);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Writable instruction memory with a byte-stream program loader. Accepts the program image as a handshaked little-endian byte stream, writes it into a byte-addressed array, and zero-pads the final partial word. Once loaded, releases the CPU from reset and serves 32-bit instruction fetches by PC, with the same byte ordering as the instruction ROM. It replaces the file-initialised ROM wherever the program must be delivered at run time.

## Interface
- ADDRESS_WIDTH, 12: byte-address width; capacity is 2**ADDRESS_WIDTH bytes.
- DATA_WIDTH, 8: storage element width; fixed at one byte.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_data  input  8  program byte.
- in_valid  input  1  in_data is valid.
- in_last  input  1  marks the final byte of the image; qualified by in_valid.
- in_ready  output  1  loader accepts a byte this cycle.
- PC  input  ADDRESS_WIDTH  fetch byte address.
- instr  output  32  fetched instruction.
- cpu_rst_n  output  1  active-low CPU reset; high only when the load has completed.
- load_err  output  1  sticky overflow flag.
- byte_count  output  ADDRESS_WIDTH+1  number of stream bytes accepted; excludes pad bytes.

## Operation
- States: IDLE, LOAD, PAD, DONE, ERROR. Reset state is IDLE.
- Handshake: a byte is accepted at a rising edge when in_valid && in_ready.
  - in_ready = 1 in IDLE and LOAD, 0 in all other states.
  - in_data and in_last must hold while in_valid is high and in_ready is low.
- Write address wr_addr (ADDRESS_WIDTH bits) starts at 0. Each accepted byte is written to mem[wr_addr], then wr_addr and byte_count increment.
- Transitions on an accepted byte at address a:
  - IDLE → LOAD on the first accepted byte without in_last.
  - Byte with in_last, and (a+1) mod 4 = 0 → DONE.
  - Byte with in_last, and (a+1) mod 4 ≠ 0 → PAD.
  - Byte without in_last at a = 2**ADDRESS_WIDTH-1 → ERROR. The byte is still written.
  - A single-byte image (in_last on the first byte) goes directly from IDLE to PAD or DONE by the same rule.
- PAD: writes 0x00 at wr_addr, one byte per cycle, incrementing wr_addr until wr_addr mod 4 = 0, then → DONE. byte_count does not change.
- DONE: terminal until reset; in_valid is ignored.
- ERROR: terminal until reset; load_err = 1.
- cpu_rst_n = 1 only in DONE.
- instr:
  - In DONE: {mem[PC+3], mem[PC+2], mem[PC+1], mem[PC]}, combinational. Address arithmetic wraps modulo 2**ADDRESS_WIDTH.
  - Otherwise: 32'h00000013 (NOP).
- Reset mid-load returns to IDLE and clears wr_addr, byte_count and load_err. Memory contents are not reset; stale bytes beyond a later, shorter image remain but are never fetched by a correct program.

## Timing
- Reset values: in_ready = 1 (IDLE, but no byte is accepted while rst_n is low), cpu_rst_n = 0, load_err = 0, byte_count = 0, instr = NOP.
- Write latency: a byte accepted at edge N is readable via instr from the cycle after edge N, provided state is DONE.
- Pad cost is 3 − (a mod 4) cycles after the last byte, where a is the address of the last byte. Zero pad cycles go directly to DONE.
- cpu_rst_n rises in the cycle after the edge that enters DONE. It is glitch-free because it decodes the registered state.
- instr is combinational in PC and state; there are no fetch pipeline registers.

## Structure
- Package imem_pkg holds:
  - the state enum loader_state_t;
  - localparam NOP_INSTR = 32'h00000013;
  - the byte-per-word constant 4.
- Sub-module imem_bytes: 2**ADDRESS_WIDTH × 8 array with one synchronous byte write port and an asynchronous little-endian 32-bit read port. No reset on the array.
- imem_loader contains the FSM, wr_addr, byte_count, the pad write mux (0x00 vs in_data), and the output gating of instr.

## Test plan
- Stream 8 bytes 13 05 00 00 93 05 10 00, last on byte 8 → DONE the next cycle with no pad. PC=0 gives 32'h00000513, PC=4 gives 32'h00100593, cpu_rst_n = 1, byte_count = 8.
- Stream 6 bytes AA BB CC DD 11 22 with last → 2 PAD cycles with in_ready = 0. PC=4 gives 32'h00002211, byte_count = 6.
- Hold in_valid low for 3 cycles mid-stream, and toggle in_valid every cycle → no lost or duplicated bytes; addresses are contiguous.
- ADDRESS_WIDTH=4: stream 16 bytes with no last → ERROR after byte 16; load_err = 1, in_ready = 0, cpu_rst_n = 0, instr = NOP. Repeat with last on byte 16 → DONE.
- Assert rst_n low after 5 bytes, release, then stream 4 bytes 01 02 03 04 with last → byte_count = 4, PC=0 gives 32'h04030201.
- Before DONE, for any PC: instr = 32'h00000013 and cpu_rst_n = 0. After DONE, further in_valid pulses change nothing.
